// File: rtl/pci_pkg.sv
// Shared definitions for the PCI parity controller: bus-phase FSM encoding,
// default bus widths, status-clear strobe indices and the parity rule.
package pci_pkg;

  // Default bus widths.
  localparam int PCI_AD_W  = 32;
  localparam int PCI_CBE_W = 4;

  // Widest buses the parity helper accepts; narrower buses are zero-extended,
  // which leaves the XOR result unchanged.
  localparam int PAR_AD_MAX  = 64;
  localparam int PAR_CBE_MAX = 8;

  // Bit positions inside the write-1-clear status strobe.
  localparam int STS_SSE = 0;
  localparam int STS_DPE = 1;

  // Bus-phase tracking states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TURN = 2'd2
  } bus_state_t;

  // Even parity over AD and C/BE#: PAR must equal this value.
  function automatic logic even_parity(input logic [PAR_AD_MAX-1:0]  ad,
                                       input logic [PAR_CBE_MAX-1:0] c_be_n);
    return ^{ad, c_be_n};
  endfunction

endpackage

// File: rtl/pci_par_calc.sv
// Parity capture stage: XOR-reduces AD and C/BE# of the current clock and
// registers the result together with flags saying whether the clock was an
// address phase or a checked data transfer. The flags qualify the compare
// against PAR one clock later.
module pci_par_calc
  import pci_pkg::*;
#(
  parameter int AD_W  = PCI_AD_W,
  parameter int CBE_W = PCI_CBE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AD_W-1:0]  ad,
  input  logic [CBE_W-1:0] c_be_n,
  input  logic             cap_addr,
  input  logic             cap_data,
  output logic             calc,
  output logic             addr_vld,
  output logic             data_vld
);

  logic calc_next;

  assign calc_next = even_parity(PAR_AD_MAX'(ad), PAR_CBE_MAX'(c_be_n));

  // Register the computed parity and the phase-type flags every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calc     <= 1'b0;
      addr_vld <= 1'b0;
      data_vld <= 1'b0;
    end else begin
      calc     <= calc_next;
      addr_vld <= cap_addr;
      data_vld <= cap_data;
    end
  end

endmodule

// File: rtl/pci_parity_ctrl.sv
// PCI parity controller for one agent. Tracks bus phases, captures address
// phases and received data transfers, compares the registered parity against
// PAR one clock later and drives PERR#/SERR# plus the sticky DPE/SSE bits.
// Optional error counter output ERR_CNT is built when PCI_PAR_ERR_CNT_EN is
// defined.
module pci_parity_ctrl
  import pci_pkg::*;
#(
  parameter int AD_W  = PCI_AD_W,
  parameter int CBE_W = PCI_CBE_W
`ifdef PCI_PAR_ERR_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AD_W-1:0]  AD,
  input  logic [CBE_W-1:0] C_BE_n,
  input  logic             PAR,
  input  logic             FRAME_n,
  input  logic             IRDY_n,
  input  logic             TRDY_n,
  input  logic             RX_DATA,
  input  logic             PERR_RESP,
  input  logic             SERR_EN,
  input  logic [1:0]       STS_CLR,
  output logic             PERR_n,
  output logic             PERR_OE,
  output logic             SERR_n,
  output logic             DPE,
  output logic             SSE
`ifdef PCI_PAR_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] ERR_CNT
`endif
);

  bus_state_t state;

  logic transfer;
  logic cap_addr;
  logic cap_data;
  logic calc;
  logic addr_vld;
  logic data_vld;
  logic mismatch;
  logic addr_err;
  logic data_err;
  logic any_err;
  logic serr_fire;

  logic perr_n_reg;
  logic perr_oe_reg;
  logic serr_n_reg;
  logic dpe_reg;
  logic sse_reg;

  // A data transfer completes when both IRDY# and TRDY# are low.
  assign transfer = !IRDY_n && !TRDY_n;

  // Address phases start from IDLE or, for fast back-to-back, from TURN.
  // Data is only checked when this agent is the receiver.
  assign cap_addr = ((state == ST_IDLE) || (state == ST_TURN)) && !FRAME_n;
  assign cap_data = (state == ST_DATA) && transfer && RX_DATA;

  // Bus-phase tracker.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!FRAME_n) state <= ST_DATA;
        end
        ST_DATA: begin
          if (transfer && FRAME_n)      state <= ST_TURN;
          else if (FRAME_n && IRDY_n)   state <= ST_IDLE;
        end
        ST_TURN: begin
          state <= (!FRAME_n) ? ST_DATA : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pci_par_calc #(
    .AD_W  (AD_W),
    .CBE_W (CBE_W)
  ) u_par_calc (
    .clk      (CLK),
    .rst      (RST),
    .ad       (AD),
    .c_be_n   (C_BE_n),
    .cap_addr (cap_addr),
    .cap_data (cap_data),
    .calc     (calc),
    .addr_vld (addr_vld),
    .data_vld (data_vld)
  );

  // PAR on this clock covers the phase captured on the previous clock.
  assign mismatch  = calc ^ PAR;
  assign addr_err  = addr_vld && mismatch;
  assign data_err  = data_vld && mismatch;
  assign any_err   = addr_err || data_err;
  assign serr_fire = addr_err && SERR_EN && PERR_RESP;

  // PERR# sequencing: drive low for each data error, then drive high for
  // one clock after the last error before releasing the output enable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perr_n_reg  <= 1'b1;
      perr_oe_reg <= 1'b0;
    end else if (data_err && PERR_RESP) begin
      perr_n_reg  <= 1'b0;
      perr_oe_reg <= 1'b1;
    end else if (!perr_n_reg) begin
      perr_n_reg  <= 1'b1;
      perr_oe_reg <= 1'b1;
    end else begin
      perr_n_reg  <= 1'b1;
      perr_oe_reg <= 1'b0;
    end
  end

  // SERR# is a single-clock low pulse per enabled address parity error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      serr_n_reg <= 1'b1;
    end else begin
      serr_n_reg <= !serr_fire;
    end
  end

  // Sticky status bits; a new set wins over a simultaneous clear strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dpe_reg <= 1'b0;
      sse_reg <= 1'b0;
    end else begin
      if (any_err)                  dpe_reg <= 1'b1;
      else if (STS_CLR[STS_DPE])    dpe_reg <= 1'b0;
      if (serr_fire)                sse_reg <= 1'b1;
      else if (STS_CLR[STS_SSE])    sse_reg <= 1'b0;
    end
  end

  assign PERR_n  = perr_n_reg;
  assign PERR_OE = perr_oe_reg;
  assign SERR_n  = serr_n_reg;
  assign DPE     = dpe_reg;
  assign SSE     = sse_reg;

`ifdef PCI_PAR_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_reg;

  // Saturating error counter; a clear coinciding with an error restarts at 1
  // so the new error is not lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt_reg <= '0;
    end else if (STS_CLR[STS_DPE]) begin
      err_cnt_reg <= any_err ? CNT_W'(1) : '0;
    end else if (any_err && (err_cnt_reg != {CNT_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + CNT_W'(1);
    end
  end

  assign ERR_CNT = err_cnt_reg;
`endif

  // Only one phase type can be captured per clock.
  a_cap_excl: assert property (@(posedge CLK) disable iff (RST)
    !(cap_addr && cap_data));

  // PERR# is never driven low with the output disabled.
  a_perr_oe: assert property (@(posedge CLK) disable iff (RST)
    !PERR_n |-> PERR_OE);

  // Address phases are at least two clocks apart, so SERR# pulses are single.
  a_serr_pulse: assert property (@(posedge CLK) disable iff (RST)
    !SERR_n |=> SERR_n);

endmodule
